// File: rtl/program_loader.sv
// program_loader: assembles a UART byte stream into instruction-memory writes, then acknowledges and releases the core.
module program_loader #(
  parameter int unsigned DEPTH_WORDS = 32768,
  parameter logic [7:0]  ACK_BYTE    = 8'hAA,
  parameter logic [7:0]  ERR_BYTE    = 8'hEE
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        done
);
  localparam int IW = $clog2(DEPTH_WORDS + 1);
  typedef enum logic [2:0] {HDR, DATA, ACK, ERR, DONE} state_t;
  state_t        r_state, w_state;
  logic [1:0]    r_cnt, w_cnt;
  logic [23:0]   r_buf, w_buf;
  logic [31:0]   r_n, w_n;
  logic [IW-1:0] r_idx, w_idx;
  logic          r_we, w_we;
  logic [31:0]   r_addr, w_addr, r_wdata, w_wdata;
  logic          r_tx_valid, w_tx_valid;
  logic [7:0]    r_tx_data, w_tx_data;
  logic          r_busy, w_busy, r_done, w_done;
  logic [31:0]   w_word;
  logic          w_rx, w_last, w_hs;
  assign w_word = {rx_data, r_buf};
  assign w_rx   = rx_valid && (r_state == HDR || r_state == DATA);
  assign w_last = w_rx && r_cnt == 2'd3;
  assign w_hs   = r_tx_valid && tx_ready;
  always_comb begin
    w_state    = r_state;
    w_cnt      = w_rx ? r_cnt + 2'd1 : r_cnt;
    w_buf      = w_rx ? {rx_data, r_buf[23:8]} : r_buf;
    w_n        = r_n;
    w_idx      = r_idx;
    w_we       = 1'b0;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_tx_valid = r_tx_valid;
    w_tx_data  = r_tx_data;
    w_busy     = r_busy;
    w_done     = r_done;
    case (r_state)
      HDR: begin
        w_busy = r_busy | w_rx;
        if (w_last) begin
          w_n        = w_word;
          w_idx      = '0;
          w_state    = w_word == 32'd0 ? ACK : w_word > DEPTH_WORDS ? ERR : DATA;
          w_tx_valid = w_word == 32'd0 || w_word > DEPTH_WORDS;
          w_tx_data  = w_word == 32'd0 ? ACK_BYTE : ERR_BYTE;
        end
      end
      DATA: if (w_last) begin
        w_we    = 1'b1;
        w_addr  = 32'(r_idx) << 2;
        w_wdata = w_word;
        w_idx   = r_idx + IW'(1);
        w_state = 32'(r_idx) + 32'd1 == r_n ? ACK : DATA;
      end
      ACK, ERR: begin
        // tx_valid is set here on the cycle after the final write; header exits set it directly
        w_tx_valid = r_tx_valid ? !tx_ready : 1'b1;
        w_tx_data  = r_state == ERR ? ERR_BYTE : ACK_BYTE;
        if (w_hs) begin
          w_state = r_state == ERR ? HDR : DONE;
          w_busy  = 1'b0;
          w_done  = r_state == ACK;
          w_cnt   = 2'd0;
          w_idx   = '0;
          w_n     = 32'd0;
        end
      end
      default: w_busy = 1'b0;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= HDR;
      r_cnt      <= 2'd0;
      r_buf      <= 24'd0;
      r_n        <= 32'd0;
      r_idx      <= '0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_buf      <= w_buf;
      r_n        <= w_n;
      r_idx      <= w_idx;
      r_we       <= w_we;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_tx_valid <= w_tx_valid;
      r_tx_data  <= w_tx_data;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end
  assign tx_valid   = r_tx_valid;
  assign tx_data    = r_tx_data;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign busy       = r_busy;
  assign done       = r_done;
endmodule
